// File: rtl/pc_seq_unit.sv
// pc_seq_unit: registered fetch PC with stall, redirect, halt/resume and optional return-address stack (macro PC_RAS_EN)
module pc_seq_unit #(
   parameter int              PC_W      = 5,
   parameter int              STEP      = 1,
   parameter logic [PC_W-1:0] RESET_VEC = '0,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] target,
   input  logic            call,
   input  logic            ret,
   input  logic            halt,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus,
   output logic            pc_valid,
   output logic            halted,
   output logic            ras_empty
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t          state;
   logic            ras_hit;
   logic [PC_W-1:0] ras_top;
   assign pc_plus = pc + PC_W'(STEP);
`ifdef PC_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);
   logic [PC_W-1:0] ras [RAS_DEPTH];
   logic [PW-1:0]   tp;
   logic [PW:0]     cnt;
   logic            push, pop;
   assign ras_empty = cnt == '0;
   assign ras_top   = ras[tp];
   assign push      = state == RUN && redirect && call;
   assign ras_hit   = state == RUN && !redirect && ret;
   assign pop       = ras_hit && !ras_empty;
   // push writes one slot above the top; when full this lands on the oldest entry
   always_ff @(posedge clk)
      if (push) ras[tp + PW'(1)] <= pc_plus;
   // top pointer wraps freely; count saturates at RAS_DEPTH
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tp  <= '0;
         cnt <= '0;
      end else if (push) begin
         tp  <= tp + PW'(1);
         cnt <= (cnt == (PW+1)'(RAS_DEPTH)) ? cnt : cnt + (PW+1)'(1);
      end else if (pop) begin
         tp  <= tp - PW'(1);
         cnt <= cnt - (PW+1)'(1);
      end
`else
   logic unused_ras;
   assign ras_empty  = 1'b1;
   assign ras_top    = '0;
   assign ras_hit    = 1'b0;
   assign unused_ras = call | ret;
`endif
   // boot/run/halt sequencing with registered pc, pc_valid and halted
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= BOOT;
         pc       <= RESET_VEC;
         pc_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state    <= RUN;
               pc_valid <= ~stall;
            end
            RUN:
               if (redirect) begin
                  pc       <= target;
                  pc_valid <= ~stall;
               end else if (ras_hit) begin
                  pc       <= ras_empty ? pc_plus : ras_top;
                  pc_valid <= ~stall;
               end else if (halt) begin
                  state    <= HALT;
                  halted   <= 1'b1;
                  pc_valid <= 1'b0;
               end else begin
                  pc       <= stall ? pc : pc_plus;
                  pc_valid <= ~stall;
               end
            HALT:
               if (redirect) begin
                  state    <= RUN;
                  pc       <= target;
                  halted   <= 1'b0;
                  pc_valid <= 1'b1;
               end
            default: state <= BOOT;
         endcase
      end
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed and random checks of pc_seq_unit against a queue-based reference model
module tb_pc_seq_unit;
`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst, stall, redirect, call, ret, halt;
   logic [4:0] target, pc, pc_plus;
   logic       pc_valid, halted, ras_empty;
   int         n_tests = 0, n_fail = 0;
   int         m_pc, m_valid, m_halted, m_mode;
   int         q[$];

   pc_seq_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .target(target),
      .call(call), .ret(ret), .halt(halt), .pc(pc), .pc_plus(pc_plus),
      .pc_valid(pc_valid), .halted(halted), .ras_empty(ras_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chkall(input string tag);
      chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
      chk({tag, ".pc_plus"}, 32'(pc_plus), 32'((m_pc + 1) % 32));
      chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(m_valid));
      chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
      chk({tag, ".ras_empty"}, 32'(ras_empty), RAS_ON ? 32'(q.size() == 0) : 32'd1);
   endtask

   task automatic model_reset();
      m_pc = 0; m_valid = 0; m_halted = 0; m_mode = 0;
      q.delete();
   endtask

   // mode 0 = just out of reset, 1 = running, 2 = halted
   task automatic cyc(input string tag, input bit s, input bit rd, input int tg,
                      input bit cl, input bit rt, input bit hl);
      stall = s; redirect = rd; target = 5'(tg); call = cl; ret = rt; halt = hl;
      if (m_mode == 0) begin
         m_mode = 1; m_valid = !s;
      end else if (m_mode == 2) begin
         if (rd) begin m_pc = tg % 32; m_mode = 1; m_valid = 1; m_halted = 0; end
      end else if (rd) begin
         if (cl && RAS_ON) begin
            q.push_back((m_pc + 1) % 32);
            if (q.size() > 4) q.delete(0);
         end
         m_pc = tg % 32; m_valid = !s;
      end else if (rt && RAS_ON) begin
         m_pc = (q.size() > 0) ? q.pop_back() : (m_pc + 1) % 32;
         m_valid = !s;
      end else if (hl) begin
         m_mode = 2; m_halted = 1; m_valid = 0;
      end else begin
         if (!s) m_pc = (m_pc + 1) % 32;
         m_valid = !s;
      end
      @(posedge clk); #1;
      chkall(tag);
   endtask

   initial begin
      rst = 1'b1; stall = 0; redirect = 0; target = 0; call = 0; ret = 0; halt = 0;
      model_reset();
      #3 chkall("reset");
      @(posedge clk); #1 rst = 1'b0;
      #1 chkall("boot");
      cyc("boot_exit", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("seq", 0, 0, 0, 0, 0, 0);
      cyc("to30", 0, 1, 30, 0, 0, 0);
      cyc("to31", 0, 0, 0, 0, 0, 0);
      cyc("wrap", 0, 0, 0, 0, 0, 0);
      cyc("to6", 0, 1, 6, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 0, 0, 0, 0);
      cyc("unstall", 0, 0, 0, 0, 0, 0);
      cyc("to9", 0, 1, 9, 0, 0, 0);
      cyc("redir_stall", 1, 1, 20, 0, 0, 0);
      cyc("to12", 0, 1, 12, 0, 0, 0);
      cyc("halt", 0, 0, 0, 0, 0, 1);
      cyc("halt_stall", 1, 0, 0, 0, 0, 0);
      cyc("halt_ret", 0, 0, 0, 0, 1, 0);
      cyc("halt_halt", 0, 0, 0, 0, 0, 1);
      cyc("halt_call", 0, 0, 0, 1, 0, 0);
      cyc("resume", 0, 1, 3, 0, 0, 0);
      cyc("call_noredir", 0, 0, 0, 1, 0, 0);
      cyc("to5", 0, 1, 5, 0, 0, 0);
      cyc("call16", 0, 1, 16, 1, 0, 0);
      cyc("to17", 0, 0, 0, 0, 0, 0);
      cyc("to18", 0, 0, 0, 0, 0, 0);
      cyc("ret6", 0, 0, 0, 0, 1, 0);
      cyc("to0", 0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) cyc("calln", 0, 1, i, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc("retn", 0, 0, 0, 0, 1, 0);
      cyc("c2a", 0, 1, 10, 1, 0, 0);
      cyc("c2b", 0, 1, 20, 1, 0, 0);
      cyc("pre_rst_halt", 0, 0, 0, 0, 0, 1);
      #1 rst = 1'b1;
      model_reset();
      #1 chkall("async_rst");
      @(posedge clk); #1 rst = 1'b0;
      #1 chkall("boot2");
      cyc("boot2_exit", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         bit rd;
         rd = ($urandom_range(3) == 0);
         cyc("rand", $urandom_range(3) == 0, rd, int'($urandom_range(31)),
             rd && $urandom_range(1) == 1, $urandom_range(5) == 0, $urandom_range(9) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program-counter unit for the pipelined CPU fetch stage.
- Replaces the bare PC incrementer with a registered PC. Adds configurable width, step and reset vector.
- Supports stall, branch/jump redirect, a halt/resume state machine, and an optional return-address stack (RAS).
- Drives the instruction-memory address and the PC+STEP value passed down the IF/ID register.

Parameters:
- PC_W, 5, PC width in bits; all PC arithmetic is modulo 2^PC_W.
- STEP, 1, increment applied per sequential fetch.
- RESET_VEC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, RAS entries (power of two, >=2); used only with the RAS feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall; hold the PC.
- redirect  input  1  taken branch/jump from EX; load target.
- target  input  PC_W  redirect destination.
- call  input  1  qualifies redirect as a call (RAS push).
- ret  input  1  return; PC loads RAS top (RAS feature only).
- halt  input  1  halt request from decode.
- pc  output  PC_W  current fetch address (registered).
- pc_plus  output  PC_W  pc+STEP, combinational, wrapped.
- pc_valid  output  1  fetch address valid this cycle (registered).
- halted  output  1  unit is in HALT state (registered).
- ras_empty  output  1  RAS holds no entries; constant 1 without the feature.

Behaviour:
- Reset: one clock domain. rst is asynchronous and active-high. While rst is high: pc=RESET_VEC, pc_valid=0, halted=0, state=BOOT, RAS pointer/count=0, ras_empty=1.
- States:
  - BOOT: one cycle after rst deasserts; pc_valid=0; pc held; always moves to RUN.
  - RUN: pc_valid=1 unless stall is high.
  - HALT: pc_valid=0; halted=1; pc frozen.
- Next-PC priority in RUN, evaluated once per rising edge:
  1. redirect: pc<=target.
  2. ret (feature on): pc<=RAS top and pop; if RAS is empty, pc<=pc_plus and no pop.
  3. halt: pc held; state<=HALT.
  4. stall: pc held.
  5. Otherwise: pc<=pc_plus.
- Priority examples: redirect overrides a simultaneous stall, ret or halt. A halt that arrives with a redirect is dropped; decode must reassert it.
- HALT exit: only redirect leaves HALT. It loads target, returns to RUN and clears halted on the same edge. stall, ret, call and halt are ignored in HALT.
- pc_valid in RUN is registered as ~stall_next: it is 0 in the cycle after a stall edge and returns to 1 on the first non-stall edge.
- Wrap-around: for PC_W=5, STEP=1, pc=31 steps to 0 with no flag. pc_plus is always (pc+STEP) mod 2^PC_W.
- call without redirect: no effect.
- call with redirect: pushes pc_plus, sampled before the update, and loads target.
- Reset mid-operation: an asynchronous rst assertion in any state forces reset values immediately. The RAS contents are discarded.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - RAS_DEPTH x PC_W circular stack with top pointer and a saturating count (0..RAS_DEPTH).
  - Push on full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop decrements count; ras_empty=(count==0).
  - Push and pop in the same edge cannot occur, because redirect beats ret.
- Undefined:
  - No stack storage is built.
  - ret and call are ignored; ret is not in the priority list.
  - ras_empty is tied to 1.

Test Plan:
1. Reset release with PC_W=5, STEP=1, RESET_VEC=0 -> BOOT cycle has pc=0, pc_valid=0. Following edges give pc=1,2,3 with pc_valid=1. From pc=31, the next edge gives pc=0.
2. Stall at pc=6 for 3 cycles -> pc stays 6 for 3 edges, with pc_valid low in the cycle after each stall edge. Release -> pc=7, pc_valid=1.
3. redirect with target=20 and stall both high at pc=9 -> next pc=20. Redirect wins.
4. halt at pc=12 -> pc=12, halted=1, pc_valid=0. Stall, ret and halt pulses are ignored. redirect with target=3 -> pc=3, halted=0, pc_valid=1 on the same edge.
5. PC_RAS_EN, RAS_DEPTH=4:
   - call+redirect at pc=5, target=16 -> pc=16 and 6 is pushed.
   - ret at pc=18 -> pc=6, ras_empty=1.
   - 5 calls pushing 1,2,3,4,5, then 4 rets -> return targets 5,4,3,2; a 5th ret gives pc=pc_plus.
6. rst asserted mid-HALT with RAS count=2 -> pc=0, halted=0, pc_valid=0 and ras_empty=1 immediately, without waiting for a clock edge.
